// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and interconnect state definitions.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PORT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ic_state_t;

  // Data-phase select: values 0..7 name a slave port, the two top codes are special.
  localparam int             DP_W       = 4;
  localparam logic [DP_W-1:0] DP_DEF_ERR = 4'hE;
  localparam logic [DP_W-1:0] DP_NONE    = 4'hF;

endpackage

// File: rtl/ahb_interconnect_n_if.sv
// Bus bundle between the CPU master, the interconnect and NUM_PORTS peripheral slaves.
// Handshake: an address phase is taken when htrans is NONSEQ/SEQ and s_hready=1; a data phase ends on the first cycle with hready=1.
interface ahb_interconnect_n_if #(
  parameter int NUM_PORTS = 3
);
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [2:0]  s_hsize;
  logic [2:0]  s_hburst;
  logic [3:0]  s_hprot;
  logic [1:0]  s_htrans;
  logic        s_hmastlock;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        s_hresp;
  logic [31:0] s_hrdata;

  logic [31:0]                 m_haddr;
  logic                        m_hwrite;
  logic [2:0]                  m_hsize;
  logic [2:0]                  m_hburst;
  logic [3:0]                  m_hprot;
  logic                        m_hmastlock;
  logic [31:0]                 m_hwdata;
  logic [NUM_PORTS-1:0][1:0]   m_htrans;
  logic [NUM_PORTS-1:0]        m_hsel;
  logic                        m_hready_fb;
  logic [NUM_PORTS-1:0]        m_hready;
  logic [NUM_PORTS-1:0]        m_hresp;
  logic [NUM_PORTS-1:0][31:0]  m_hrdata;

  modport master (
    output s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock, s_hwdata,
    input  s_hready, s_hresp, s_hrdata
  );

  modport slave (
    input  m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hmastlock, m_hwdata,
    input  m_htrans, m_hsel, m_hready_fb,
    output m_hready, m_hresp, m_hrdata
  );

  modport ic (
    input  s_haddr, s_hwrite, s_hsize, s_hburst, s_hprot, s_htrans, s_hmastlock, s_hwdata,
    output s_hready, s_hresp, s_hrdata,
    output m_haddr, m_hwrite, m_hsize, m_hburst, m_hprot, m_hmastlock, m_hwdata,
    output m_htrans, m_hsel, m_hready_fb,
    input  m_hready, m_hresp, m_hrdata
  );
endinterface

// File: rtl/ahb_default_slave.sv
// Two-cycle ERROR response generator for unmapped or aborted transfers.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  ic_state_t state,
  output logic      err_ready,
  output logic      err_resp,
  output logic      err_count
);

  // ERR1 stretches the transfer so the master sees hresp=1 before hready=1.
  always_comb begin
    err_ready = (state == ST_ERR2);
    err_resp  = HRESP_ERROR;
    err_count = (state == ST_ERR1);
  end

endmodule

// File: rtl/ahb_interconnect_n.sv
// Single-master AHB-Lite interconnect to NUM_PORTS slaves with default slave and error counter.
// Optional stalled-slave timeout and hung-port masking when AHB_TIMEOUT_EN is defined.
module ahb_interconnect_n
  import ahb_pkg::*;
#(
  parameter int NUM_PORTS      = 3,
  parameter int SEL_LSB        = 12,
  parameter int SEL_W          = 3,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ERRCNT_W       = 16
) (
  input  logic                clk,
  input  logic                resetn,
  ahb_interconnect_n_if.ic    bus,
  output logic [ERRCNT_W-1:0] err_cnt,
  output ic_state_t           dbg_state
);

  localparam int               NSEL = 1 << SEL_W;
  localparam logic [SEL_W:0]   NP   = (SEL_W+1)'(NUM_PORTS);

  if (NUM_PORTS < 1 || NUM_PORTS > 8 || NUM_PORTS > NSEL || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("ahb_interconnect_n: illegal parameter combination");
  end

  ic_state_t            state, state_nxt;
  logic [DP_W-1:0]      dp_sel, dp_nxt;
  logic [SEL_W-1:0]     idx;
  logic [NUM_PORTS-1:0] hung;
  logic [NSEL-1:0]      hung_ext;
  logic                 mapped, active, hready, timeout;
  logic                 sel_ready, sel_resp;
  logic [31:0]          sel_rdata;
  logic                 err_ready, err_resp, err_count, err_inc;

  assign idx    = bus.s_haddr[SEL_LSB+SEL_W-1:SEL_LSB];
  assign active = bus.s_htrans[1];

  always_comb begin
    hung_ext = '0;
    for (int k = 0; k < NUM_PORTS; k++) hung_ext[k] = hung[k];
  end

  assign mapped = ({1'b0, idx} < NP) && !hung_ext[idx];

  assign bus.m_haddr     = bus.s_haddr;
  assign bus.m_hwrite    = bus.s_hwrite;
  assign bus.m_hsize     = bus.s_hsize;
  assign bus.m_hburst    = bus.s_hburst;
  assign bus.m_hprot     = bus.s_hprot;
  assign bus.m_hmastlock = bus.s_hmastlock;
  assign bus.m_hwdata    = bus.s_hwdata;

  always_comb begin
    bus.m_hsel   = '0;
    bus.m_htrans = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      bus.m_hsel[k]   = mapped && (idx == SEL_W'(k));
      bus.m_htrans[k] = bus.m_hsel[k] ? bus.s_htrans : HTRANS_IDLE;
    end
  end

  // NONE and DEF_ERR fall through to an idle OKAY here.
  always_comb begin
    sel_ready = 1'b1;
    sel_resp  = HRESP_OKAY;
    sel_rdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (dp_sel == DP_W'(k)) begin
        sel_ready = bus.m_hready[k];
        sel_resp  = bus.m_hresp[k];
        sel_rdata = bus.m_hrdata[k];
      end
    end
  end

  ahb_default_slave u_default_slave (
    .state     (state),
    .err_ready (err_ready),
    .err_resp  (err_resp),
    .err_count (err_count)
  );

  always_comb begin
    if (state == ST_ERR1 || state == ST_ERR2) begin
      hready       = err_ready;
      bus.s_hresp  = err_resp;
      bus.s_hrdata = '0;
    end else begin
      hready       = sel_ready;
      bus.s_hresp  = sel_resp;
      bus.s_hrdata = sel_rdata;
    end
  end

  assign bus.s_hready    = hready;
  assign bus.m_hready_fb = hready;
  assign dbg_state       = state;

`ifdef AHB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt;
  logic             stall;

  assign stall   = (state == ST_PORT) && !sel_ready;
  assign timeout = stall && (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                stall_cnt <= '0;
    else if (hready || timeout) stall_cnt <= '0;
    else if (stall)             stall_cnt <= stall_cnt + 1'b1;
  end

  // A hung port recovers only once it shows ready while nothing is waiting on it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hung <= '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (timeout && dp_sel == DP_W'(k))
          hung[k] <= 1'b1;
        else if (bus.m_hready[k] && !(state == ST_PORT && dp_sel == DP_W'(k)))
          hung[k] <= 1'b0;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign hung    = '0;
`endif

  always_comb begin
    state_nxt = state;
    dp_nxt    = dp_sel;
    if (hready) begin
      if (active && mapped) begin
        state_nxt = ST_PORT;
        dp_nxt    = DP_W'(idx);
      end else if (active) begin
        state_nxt = ST_ERR1;
        dp_nxt    = DP_DEF_ERR;
      end else begin
        state_nxt = ST_IDLE;
        dp_nxt    = DP_NONE;
      end
    end else if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (timeout) begin
      state_nxt = ST_ERR1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_IDLE;
      dp_sel <= DP_NONE;
    end else begin
      state  <= state_nxt;
      dp_sel <= dp_nxt;
    end
  end

  // A slave ERROR is counted once, on its final (hready=1) cycle.
  assign err_inc = err_count || (state == ST_PORT && sel_ready && sel_resp);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       err_cnt <= '0;
    else if (err_inc && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
  end

endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Directed bench for ahb_interconnect_n: decode, wait states, default slave, pipelining, reset.
module tb_ahb_interconnect_n;
  import ahb_pkg::*;

  logic        clk;
  logic        resetn;
  logic [15:0] err_cnt;
  ic_state_t   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [32:0] exp_q[$];

  ahb_interconnect_n_if #(.NUM_PORTS(3)) bus ();

  ahb_interconnect_n #(
    .NUM_PORTS      (3),
    .SEL_LSB        (12),
    .SEL_W          (3),
    .TIMEOUT_CYCLES (8),
    .ERRCNT_W       (16)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus.ic),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic master_idle();
    bus.s_haddr     = 32'h0;
    bus.s_hwrite    = 1'b0;
    bus.s_hsize     = 3'b010;
    bus.s_hburst    = 3'b000;
    bus.s_hprot     = 4'b0011;
    bus.s_htrans    = HTRANS_IDLE;
    bus.s_hmastlock = 1'b0;
    bus.s_hwdata    = 32'h0;
  endtask

  task automatic master_addr(input logic [31:0] addr, input logic wr);
    bus.s_haddr  = addr;
    bus.s_hwrite = wr;
    bus.s_htrans = HTRANS_NONSEQ;
  endtask

  task automatic slaves_ok();
    bus.m_hready = '1;
    bus.m_hresp  = '0;
    bus.m_hrdata = '0;
  endtask

  task automatic check_resp(input string tag, input logic rdy, input logic rsp);
    check({tag, "_hready"}, 32'(bus.s_hready), 32'(rdy));
    check({tag, "_hresp"},  32'(bus.s_hresp),  32'(rsp));
  endtask

  // scoreboard: each completed data phase pops {hresp, hrdata}
  task automatic sb_sample();
    logic [32:0] e;
    if (bus.s_hready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_resp",  32'(bus.s_hresp), 32'(e[32]));
        check("sb_rdata", bus.s_hrdata,     e[31:0]);
      end
    end
  endtask

  initial begin
    resetn = 1'b0;
    master_idle();
    slaves_ok();
    repeat (2) @(posedge clk);
    #1;
    check_resp("rst", 1'b1, 1'b0);
    check("rst_rdata", bus.s_hrdata, 32'h0);
    check("rst_errcnt", 32'(err_cnt), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    resetn = 1'b1;

    // decode to port 1, zero wait states
    master_addr(32'h0000_1004, 1'b0);
    #1;
    check("dec_hsel", 32'(bus.m_hsel), 32'b010);
    check("dec_htrans", 32'(bus.m_htrans), 32'b00_10_00);
    check("dec_haddr", bus.m_haddr, 32'h0000_1004);
    step();
    master_idle();
    bus.m_hrdata[1] = 32'hDEAD_BEEF;
    #1;
    check_resp("dec_dp", 1'b1, 1'b0);
    check("dec_rdata", bus.s_hrdata, 32'hDEAD_BEEF);
    check("dec_state", 32'(dbg_state), 32'(ST_PORT));
    step();
    slaves_ok();

    // port 2 write with three wait states, next address held by the master
    master_addr(32'h0000_2000, 1'b1);
    #1;
    check("ws_hsel", 32'(bus.m_hsel), 32'b100);
    step();
    master_addr(32'h0000_0008, 1'b0);
    bus.s_hwdata    = 32'h1234_5678;
    bus.m_hready[2] = 1'b0;
    bus.m_hrdata[2] = 32'h2222_2222;
    bus.m_hrdata[0] = 32'h0A0A_0A0A;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ws_stall_hready", 32'(bus.s_hready), 32'h0);
      check("ws_stall_rdata", bus.s_hrdata, 32'h2222_2222);
      check("ws_hwdata", bus.m_hwdata, 32'h1234_5678);
      step();
    end
    bus.m_hready[2] = 1'b1;
    #1;
    check_resp("ws_end", 1'b1, 1'b0);
    step();
    master_idle();
    #1;
    check("ws_next_rdata", bus.s_hrdata, 32'h0A0A_0A0A);
    check("ws_next_state", 32'(dbg_state), 32'(ST_PORT));
    step();
    slaves_ok();

    // unmapped NONSEQ -> two-cycle ERROR, then IDLE to the same address
    master_addr(32'h0000_5000, 1'b0);
    #1;
    check("um_hsel", 32'(bus.m_hsel), 32'b000);
    check("um_htrans", 32'(bus.m_htrans), 32'b00_00_00);
    step();
    master_idle();
    #1;
    check_resp("um_err1", 1'b0, 1'b1);
    check("um_err1_cnt", 32'(err_cnt), 32'd0);
    check("um_err1_state", 32'(dbg_state), 32'(ST_ERR1));
    step();
    #1;
    check_resp("um_err2", 1'b1, 1'b1);
    check("um_err2_cnt", 32'(err_cnt), 32'd1);
    step();
    bus.s_haddr = 32'h0000_5000;
    #1;
    check_resp("um_after", 1'b1, 1'b0);
    step();
    #1;
    check_resp("um_idle", 1'b1, 1'b0);
    check("um_idle_cnt", 32'(err_cnt), 32'd1);
    step();

    // back-to-back port0 -> unmapped -> port1
    exp_q.push_back({HRESP_OKAY,  32'h0000_AAAA});
    exp_q.push_back({HRESP_ERROR, 32'h0000_0000});
    exp_q.push_back({HRESP_OKAY,  32'h0000_BBBB});
    master_addr(32'h0000_0010, 1'b0);
    step();
    master_addr(32'h0000_5000, 1'b0);
    bus.m_hrdata[0] = 32'h0000_AAAA;
    #1;
    sb_sample();
    step();
    master_addr(32'h0000_1000, 1'b0);
    #1;
    check("b2b_err1_hready", 32'(bus.s_hready), 32'h0);
    sb_sample();
    step();
    #1;
    check("b2b_err2_hsel", 32'(bus.m_hsel), 32'b010);
    sb_sample();
    step();
    master_idle();
    bus.m_hrdata[1] = 32'h0000_BBBB;
    #1;
    sb_sample();
    check("b2b_state", 32'(dbg_state), 32'(ST_PORT));
    check("b2b_q_empty", 32'(exp_q.size()), 32'd0);
    check("b2b_cnt", 32'(err_cnt), 32'd2);
    step();
    slaves_ok();

    // slave-generated ERROR is forwarded and counted once
    master_addr(32'h0000_1000, 1'b0);
    step();
    master_idle();
    bus.m_hready[1] = 1'b0;
    bus.m_hresp[1]  = 1'b1;
    #1;
    check_resp("serr1", 1'b0, 1'b1);
    check("serr1_cnt", 32'(err_cnt), 32'd2);
    step();
    bus.m_hready[1] = 1'b1;
    #1;
    check_resp("serr2", 1'b1, 1'b1);
    step();
    slaves_ok();
    #1;
    check("serr_cnt", 32'(err_cnt), 32'd3);
    check_resp("serr_after", 1'b1, 1'b0);

`ifdef AHB_TIMEOUT_EN
    // port0 stuck: ERROR after 8 stall cycles, then port0 masked until it recovers
    master_addr(32'h0000_0000, 1'b0);
    step();
    master_idle();
    bus.m_hready[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("to_stall_hready", 32'(bus.s_hready), 32'h0);
      check("to_stall_state", 32'(dbg_state), 32'(ST_PORT));
      step();
    end
    #1;
    check("to_err1_state", 32'(dbg_state), 32'(ST_ERR1));
    check_resp("to_err1", 1'b0, 1'b1);
    step();
    #1;
    check_resp("to_err2", 1'b1, 1'b1);
    check("to_cnt", 32'(err_cnt), 32'd4);
    master_addr(32'h0000_0000, 1'b0);
    #1;
    check("to_hung_hsel", 32'(bus.m_hsel), 32'b000);
    step();
    master_idle();
    #1;
    check("to_hung_state", 32'(dbg_state), 32'(ST_ERR1));
    step();
    bus.m_hready[0] = 1'b1;
    #1;
    check("to_hung_cnt", 32'(err_cnt), 32'd5);
    step();
    master_addr(32'h0000_0000, 1'b0);
    #1;
    check("to_recover_hsel", 32'(bus.m_hsel), 32'b001);
    step();
    master_idle();
    #1;
    check_resp("to_recover", 1'b1, 1'b0);
    step();
`endif

    // asynchronous reset during a port1 wait state
    master_addr(32'h0000_1000, 1'b0);
    step();
    master_idle();
    bus.m_hready[1] = 1'b0;
    bus.m_hrdata[1] = 32'h5555_5555;
    #1;
    check("rst_mid_hready", 32'(bus.s_hready), 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    check_resp("rst_mid", 1'b1, 1'b0);
    check("rst_mid_rdata", bus.s_hrdata, 32'h0);
    check("rst_mid_cnt", 32'(err_cnt), 32'h0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    resetn = 1'b1;
    slaves_ok();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
